shift_pipe: RTL and testbench

Parametrised, pipelined barrel-shift unit for the integer execute path. It performs logical left, logical right, arithmetic right and rotate right on an XLEN-bit operand. Stage order is 2^(SH-1) first, down to 1. A register slice is inserted after every REG_EVERY stages, and a valid/ready handshake carries a destination tag so that a multi-cycle execute stage can retire results in order.

---
 rtl/shift_pipe.sv | 151 +++++++++++++++
 tb/tb_shift_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with a valid/ready handshake and a
// pass-through destination tag. Stages shift by 2^(SH-1) down to 1, and a register follows every REG_EVERY stages.
module shift_pipe #(
  parameter int XLEN      = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_rd,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SH   = $clog2(XLEN);
  localparam int NREG = (SH + REG_EVERY - 1) / REG_EVERY;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // One slot per pipeline register; the last slot drives the outputs.
  logic             valid_q [NREG];
  logic             valid_d [NREG];
  logic [XLEN-1:0]  data_q  [NREG];
  logic [XLEN-1:0]  data_d  [NREG];
  logic [SH-1:0]    amt_q   [NREG];
  logic [SH-1:0]    amt_d   [NREG];
  logic [1:0]       op_q    [NREG];
  logic [1:0]       op_d    [NREG];
  logic             sign_q  [NREG];
  logic             sign_d  [NREG];
  logic [TAG_W-1:0] tag_q   [NREG];
  logic [TAG_W-1:0] tag_d   [NREG];

  logic stall;

  function automatic logic [XLEN-1:0] shift_stage(
    input logic [XLEN-1:0] d,
    input logic [1:0]      op,
    input logic            sign,
    input int              s
  );
    logic [XLEN-1:0] fill;
    fill = ~({XLEN{1'b1}} >> s);
    case (op)
      OP_SLL:  return d << s;
      OP_SRL:  return d >> s;
      OP_SRA:  return (d >> s) | (sign ? fill : '0);
      OP_ROR:  return (d >> s) | (d << (XLEN - s));
      default: return d;
    endcase
  endfunction

  assign stall    = valid_q[NREG-1] && !out_ready;
  assign in_ready = !stall;

  always_comb begin : next_state
    logic             cur_valid;
    logic [XLEN-1:0]  cur_data;
    logic [SH-1:0]    cur_amt;
    logic [1:0]       cur_op;
    logic             cur_sign;
    logic [TAG_W-1:0] cur_tag;
    // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
    cur_valid = 1'b0;
    cur_data  = '0;
    cur_amt   = '0;
    cur_op    = '0;
    cur_sign  = 1'b0;
    cur_tag   = '0;
    for (int g = 0; g < NREG; g++) begin
      valid_d[g] = valid_q[g];
      data_d[g]  = data_q[g];
      amt_d[g]   = amt_q[g];
      op_d[g]    = op_q[g];
      sign_d[g]  = sign_q[g];
      tag_d[g]   = tag_q[g];
      if (g == 0) begin
        cur_valid = in_valid;
        cur_data  = in_rs1;
        cur_amt   = in_rs2[SH-1:0];
        cur_op    = in_op;
        cur_sign  = in_rs1[XLEN-1];
        cur_tag   = in_tag;
      end else begin
        cur_valid = valid_q[g-1];
        cur_data  = data_q[g-1];
        cur_amt   = amt_q[g-1];
        cur_op    = op_q[g-1];
        cur_sign  = sign_q[g-1];
        cur_tag   = tag_q[g-1];
      end
      // Stage index i handles shift distance 2^(SH-1-i); group g owns stages g*REG_EVERY onward.
      for (int i = 0; i < SH; i++) begin
        if ((i / REG_EVERY) == g && cur_amt[SH-1-i]) begin
          cur_data = shift_stage(cur_data, cur_op, cur_sign, 1 << (SH - 1 - i));
        end
      end
      if (!stall) begin
        valid_d[g] = cur_valid;
        data_d[g]  = cur_data;
        amt_d[g]   = cur_amt;
        op_d[g]    = cur_op;
        sign_d[g]  = cur_sign;
        tag_d[g]   = cur_tag;
      end
    end
  end

  // Datapath fields are reset too so out_rd/out_tag read zero after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every slot samples pre-edge values.
    if (rst) begin
      for (int g = 0; g < NREG; g++) begin
        valid_q[g] <= 1'b0;
        data_q[g]  <= '0;
        amt_q[g]   <= '0;
        op_q[g]    <= '0;
        sign_q[g]  <= 1'b0;
        tag_q[g]   <= '0;
      end
    end else begin
      for (int g = 0; g < NREG; g++) begin
        valid_q[g] <= valid_d[g];
        data_q[g]  <= data_d[g];
        amt_q[g]   <= amt_d[g];
        op_q[g]    <= op_d[g];
        sign_q[g]  <= sign_d[g];
        tag_q[g]   <= tag_d[g];
      end
    end
  end

  assign out_valid = valid_q[NREG-1];
  assign out_rd    = data_q[NREG-1];
  assign out_tag   = tag_q[NREG-1];

  // Upper shift-amount bits and the control fields of the final slot have no consumer.
  logic unused_bits;
  assign unused_bits = ^{in_rs2[XLEN-1:SH], amt_q[NREG-1], op_q[NREG-1], sign_q[NREG-1]};

endmodule

// File: tb/tb_shift_pipe.sv
// Directed, table-driven bench for shift_pipe at default parameters (XLEN=32, NREG=3),
// plus hand-written backpressure, reset and randomized scoreboard sequences.
module tb_shift_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int NREG  = 3;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_rd;
  logic [TAG_W-1:0] out_tag;

  shift_pipe #(.XLEN(XLEN), .REG_EVERY(2), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  exp;
  } vec_t;

  vec_t vecs [10];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference shifter written directly from the operation definitions.
  function automatic logic [XLEN-1:0] ref_shift(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    int n;
    n = int'(b[4:0]);
    case (op)
      SLL:     return a << n;
      SRL:     return a >> n;
      SRA:     return XLEN'($signed(a) >>> n);
      default: return (a >> n) | (a << (XLEN - n));
    endcase
  endfunction

  // Called at posedge+1; issues one request and waits for its result.
  task automatic run_vector(input vec_t v, input string name);
    int lat;
    bit got;
    in_valid = 1'b1; in_op = v.op; in_rs1 = v.rs1; in_rs2 = v.rs2; in_tag = v.tag;
    #1;
    check({name, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    got = out_valid;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      got = out_valid;
    end
    check({name, "_latency"}, lat, NREG);
    check({name, "_rd"}, out_rd, v.exp);
    check({name, "_tag"}, out_tag, v.tag);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{SLL, 32'h8000_00F1, 32'd4,          5'd1, 32'h0000_0F10};
    vecs[1] = '{SRL, 32'h8000_00F1, 32'd4,          5'd2, 32'h0800_000F};
    vecs[2] = '{SRA, 32'h8000_00F1, 32'd4,          5'd3, 32'hF800_000F};
    vecs[3] = '{ROR, 32'h8000_00F1, 32'd4,          5'd4, 32'h1800_000F};
    vecs[4] = '{SRL, 32'hFFFF_FFFF, 32'h0000_0120,  5'd5, 32'hFFFF_FFFF};
    vecs[5] = '{SRL, 32'hFFFF_FFFF, 32'd31,         5'd6, 32'h0000_0001};
    vecs[6] = '{SRA, 32'h7FFF_FFFF, 32'd31,         5'd7, 32'h0000_0000};
    vecs[7] = '{ROR, 32'h1234_5678, 32'd16,         5'd8, 32'h5678_1234};
    vecs[8] = '{SLL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5'd9, 32'h8000_0000};
    vecs[9] = '{SRA, 32'h8000_0000, 32'h0000_001F, 5'd31, 32'hFFFF_FFFF};

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_rd", out_rd, '0);
    check("reset_out_tag", out_tag, '0);
    check("reset_in_ready", in_ready, 1'b1);

    // Single-request table.
    for (int i = 0; i < 10; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back SLL of 1 by k, tags 0..7: accept and drain on the same edges.
    for (int cyc = 1; cyc <= 12; cyc++) begin
      in_valid = (cyc <= 8);
      in_op = SLL; in_rs1 = 32'd1; in_rs2 = XLEN'(cyc - 1); in_tag = TAG_W'(cyc - 1);
      @(posedge clk); #1;
      if (cyc >= 3 && cyc <= 10) begin
        check($sformatf("b2b_valid_%0d", cyc), out_valid, 1'b1);
        check($sformatf("b2b_rd_%0d", cyc), out_rd, 32'd1 << (cyc - 3));
        check($sformatf("b2b_tag_%0d", cyc), out_tag, cyc - 3);
      end else begin
        check($sformatf("b2b_idle_%0d", cyc), out_valid, 1'b0);
      end
    end
    in_valid = 1'b0;

    // Backpressure: 4 requests, 5 stalled cycles once the first result shows.
    begin
      logic [XLEN-1:0]  exp_rd  [4];
      logic [TAG_W-1:0] exp_tag [4];
      int issued, recv, stall_left, stall_cycles;
      bit started, acc, drn;
      issued = 0; recv = 0; stall_left = 0; stall_cycles = 0; started = 1'b0;
      for (int j = 0; j < 4; j++) begin
        exp_rd[j]  = 32'h0000_0F00 >> j;
        exp_tag[j] = TAG_W'(j + 10);
      end
      for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
        if (out_valid && !started) begin started = 1'b1; stall_left = 5; end
        out_ready = (stall_left == 0);
        in_valid = (issued < 4);
        in_op = SRL; in_rs1 = 32'h0000_0F00; in_rs2 = XLEN'(issued); in_tag = TAG_W'(issued + 10);
        #1;
        check("bp_in_ready", in_ready, (stall_left == 0) ? 1'b1 : 1'b0);
        if (!in_ready) stall_cycles++;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (out_valid) begin
          check($sformatf("bp_rd_%0d", recv), out_rd, exp_rd[recv]);
          check($sformatf("bp_tag_%0d", recv), out_tag, exp_tag[recv]);
        end
        @(posedge clk); #1;
        if (acc) issued++;
        if (drn) recv++;
        if (stall_left > 0) stall_left--;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("bp_received", recv, 4);
      check("bp_stall_cycles", stall_cycles, 5);
      repeat (3) begin
        @(posedge clk); #1;
        check("bp_no_duplicate", out_valid, 1'b0);
      end
    end

    // Reset mid-flight, with a request held on in_valid during the reset edge.
    out_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1; in_op = SLL; in_rs1 = 32'd3; in_rs2 = XLEN'(j); in_tag = TAG_W'(20 + j);
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b1; in_rs2 = 32'd5; in_tag = 5'd22;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid_now", out_valid, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst_quiet_%0d", c), out_valid, 1'b0);
    end
    begin
      vec_t v;
      v = '{ROR, 32'h0000_0001, 32'd1, 5'd17, 32'h8000_0000};
      run_vector(v, "rst_ror");
    end

    // Random traffic against the reference model with random backpressure.
    begin
      logic [XLEN-1:0]  q_rd  [$];
      logic [TAG_W-1:0] q_tag [$];
      bit acc, drn;
      for (int cyc = 0; cyc < 400; cyc++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_op     = 2'($urandom_range(0, 3));
        in_rs1    = $urandom;
        in_rs2    = $urandom;
        in_tag    = TAG_W'($urandom);
        #1;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (out_valid) begin
          if (q_rd.size() == 0) check("rand_spurious", out_valid, 1'b0);
          else if (drn) begin
            check("rand_rd", out_rd, q_rd.pop_front());
            check("rand_tag", out_tag, q_tag.pop_front());
          end
        end
        if (acc) begin
          q_rd.push_back(ref_shift(in_op, in_rs1, in_rs2));
          q_tag.push_back(in_tag);
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 20 && q_rd.size() > 0; c++) begin
        if (out_valid) begin
          check("rand_drain_rd", out_rd, q_rd.pop_front());
          check("rand_drain_tag", out_tag, q_tag.pop_front());
        end
        @(posedge clk); #1;
      end
      check("rand_all_drained", q_rd.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
